// File: rtl/button_conditioner.sv
// Conditions an active-low push-button into a debounced level, press/release pulses and a long-press flag.
// Define BUTTON_AUTOREPEAT_EN to build the auto-repeat pulse generator; otherwise repeatpulse is tied low.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 1000000,
  parameter int REPEAT_CYCLES   = 250000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic switchin,
  output logic pressed,
  output logic presspulse,
  output logic releasepulse,
  output logic longpress,
  output logic repeatpulse
);

  localparam logic [CNT_WIDTH-1:0] DEB_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LONG_MAX = CNT_WIDTH'(LONG_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cycles
    $error("button_conditioner: cycle parameters must be >= 1");
  end

  // bit0 is the debounced level, bit1 the long-press flag, so both outputs come straight off flops
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HELD = 2'b01,
    LONG = 2'b11
  } state_t;

  state_t               state, state_nxt;
  logic                 sync1, s;
  logic [CNT_WIDTH-1:0] dcnt, hcnt;
  logic                 accept;

  assign pressed   = state[0];
  assign longpress = state[1];
  assign accept    = (s != pressed) && (dcnt == DEB_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= ~switchin;
      s     <= sync1;
    end
  end

  // any sample agreeing with the current level restarts the count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 dcnt <= '0;
    else if (s == pressed || accept) dcnt <= '0;
    else                          dcnt <= dcnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HELD;
      HELD:    if (accept) state_nxt = IDLE;
               else if (hcnt == LONG_MAX) state_nxt = LONG;
      LONG:    if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hcnt         <= '0;
      presspulse   <= 1'b0;
      releasepulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      presspulse   <= accept & ~pressed;
      releasepulse <= accept & pressed;
      case (state)
        IDLE:    hcnt <= '0;
        HELD:    hcnt <= accept ? '0 : hcnt + 1'b1;
        default: hcnt <= accept ? '0 : hcnt;
      endcase
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REP_MAX = CNT_WIDTH'(REPEAT_CYCLES - 1);
  logic [CNT_WIDTH-1:0] rcnt;

  // a release accepted on the same edge suppresses the pulse that would have landed there
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rcnt        <= '0;
      repeatpulse <= 1'b0;
    end else if (state == LONG && !accept) begin
      if (rcnt == REP_MAX) begin
        rcnt        <= '0;
        repeatpulse <= 1'b1;
      end else begin
        rcnt        <= rcnt + 1'b1;
        repeatpulse <= 1'b0;
      end
    end else begin
      rcnt        <= '0;
      repeatpulse <= 1'b0;
    end
  end
`else
  assign repeatpulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner: a history-based model of the debounce/hold rules checked every cycle.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LNG  = 10;
  localparam int REP  = 3;
  localparam int CW   = 8;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  logic switchin;
  logic pressed, presspulse, releasepulse, longpress, repeatpulse;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .switchin(switchin),
    .pressed(pressed), .presspulse(presspulse), .releasepulse(releasepulse),
    .longpress(longpress), .repeatpulse(repeatpulse)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pushed-history per edge since reset; s seen at edge e is the button two edges earlier.
  bit ph [0:8191];
  int e = 0, last_tog = -DEB, press_edge = 0;
  bit mp = 1'b0;
  bit exp_pressed = 0, exp_press = 0, exp_rel = 0, exp_long = 0, exp_rep = 0;

  function automatic bit s_at(input int k);
    if (k < 2) return 1'b0;
    return ph[k-2];
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      e = 0; last_tog = -DEB; mp = 1'b0; press_edge = 0;
      exp_pressed = 0; exp_press = 0; exp_rel = 0; exp_long = 0; exp_rep = 0;
    end else begin
      bit tog;
      int since;
      if (e < 8192) ph[e] = ~switchin;
      tog = (e - last_tog >= DEB);
      for (int k = 0; k < DEB; k++)
        if (s_at(e - k) == mp) tog = 1'b0;
      exp_press = tog && !mp;
      exp_rel   = tog && mp;
      if (tog) begin
        mp = !mp;
        last_tog = e;
        if (mp) press_edge = e;
      end
      exp_pressed = mp;
      exp_long    = mp && (e - press_edge >= LNG);
      since       = e - press_edge - LNG;
      exp_rep     = REP_EN && exp_long && (since > 0) && (since % REP == 0);
      e++;
    end
  end

  always @(negedge clock) begin
    check("pressed", pressed, exp_pressed);
    check("presspulse", presspulse, exp_press);
    check("releasepulse", releasepulse, exp_rel);
    check("longpress", longpress, exp_long);
    check("repeatpulse", repeatpulse, exp_rep);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called right after reset_n is released with the button held low.
  task automatic held_after_reset(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 4)  check({tag, "_not_yet"}, pressed, 1'b0);
      if (i == 5)  begin check({tag, "_pressed"}, pressed, 1'b1); check({tag, "_pp"}, presspulse, 1'b1); end
      if (i == 6)  check({tag, "_pp_once"}, presspulse, 1'b0);
      if (i == 14) check({tag, "_long_pre"}, longpress, 1'b0);
      if (i == 15) check({tag, "_long"}, longpress, 1'b1);
      if (i == 17) check({tag, "_rep_pre"}, repeatpulse, 1'b0);
      if (i == 18) check({tag, "_rep_first"}, repeatpulse, REP_EN);
      if (i == 19) check({tag, "_rep_gap"}, repeatpulse, 1'b0);
    end
  endtask

  initial begin
    int pc, rc, prise, lrise, lvl, run;
    bit seen;
    reset_n = 1'b0;
    switchin = 1'b0;
    #1 check("reset_pressed", pressed, 1'b0);
    check("reset_long", longpress, 1'b0);
    cycles(3);
    #2 reset_n = 1'b1;
    held_after_reset("rst");
    switchin = 1'b1;
    cycles(12);

    // clean press / release
    pc = 0; rc = 0;
    switchin = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clock); pc += int'(presspulse); end
    switchin = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      rc += int'(releasepulse);
      if (i == 4) check("clean_rel_pre", pressed, 1'b1);
      if (i == 5) check("clean_rel", releasepulse, 1'b1);
    end
    check("clean_press_once", pc == 1, 1'b1);
    check("clean_rel_once", rc == 1, 1'b1);

    // bounce shorter than the debounce window
    seen = 1'b0; lvl = 0; run = 0;
    for (int i = 0; i < 30; i++) begin
      if (run == 0) begin lvl = 1 - lvl; run = $urandom_range(1, 3); end
      switchin = lvl[0];
      run--;
      @(negedge clock);
      seen |= pressed | presspulse | releasepulse;
    end
    switchin = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clock); seen |= pressed | presspulse | releasepulse; end
    check("bounce_quiet", seen, 1'b0);

    // long press
    prise = -1; lrise = -1;
    switchin = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (pressed && prise < 0) prise = i;
      if (longpress && lrise < 0) lrise = i;
    end
    check("long_delay", (lrise - prise) == LNG, 1'b1);
    switchin = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (!pressed) check("long_falls_with_pressed", longpress, 1'b0);
    end

    // reset while in LONG with the button still held
    switchin = 1'b0;
    cycles(20);
    check("midhold_long", longpress, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("midhold_pressed_drop", pressed, 1'b0);
    check("midhold_long_drop", longpress, 1'b0);
    check("midhold_no_rel", releasepulse, 1'b0);
    cycles(2);
    #2 reset_n = 1'b1;
    held_after_reset("midhold");
    switchin = 1'b1;
    cycles(12);

    // random runs with occasional resets
    lvl = 1;
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        #2 reset_n = 1'b0;
        cycles($urandom_range(1, 3));
        #2 reset_n = 1'b1;
      end else begin
        lvl = ($urandom_range(0, 3) == 0) ? lvl : 1 - lvl;
        switchin = lvl[0];
        cycles($urandom_range(1, 30));
      end
    end
    switchin = 1'b1;
    cycles(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for the active-low board push-buttons that drive the execution controller's start/stop request. It synchronises the raw switch into the `clock` domain, debounces it with a consecutive-sample counter, and produces a clean level, single-cycle press and release pulses, and a long-press indication. It sits directly upstream of the phase-clock controller, whose stop/start toggle consumes `presspulse`.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable synchronised samples required to accept a change (≥1).
- `LONG_CYCLES`, default 1000000: cycles `pressed` must stay high before `longpress` asserts (≥1).
- `REPEAT_CYCLES`, default 250000: auto-repeat period (used only with the macro, ≥1).
- `CNT_WIDTH`, default 20: width of all internal counters. It must hold `max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)`.

Ports:
- `clock`  in  1  system clock; all flops on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `switchin`  in  1  raw button, active-low (0 = pushed), asynchronous to `clock`.
- `pressed`  out  1  debounced level, 1 = pushed.
- `presspulse`  out  1  one-cycle pulse when `pressed` rises.
- `releasepulse`  out  1  one-cycle pulse when `pressed` falls.
- `longpress`  out  1  level, high while held ≥ `LONG_CYCLES`.
- `repeatpulse`  out  1  auto-repeat pulse (see Configuration).

## Operation
- Synchroniser: two flops on `~switchin`, both reset to 0 (released). The output of the second flop is `s`.
- Debounce counter `dcnt`:
  - Cleared whenever `s == pressed`.
  - Otherwise increments by 1.
  - When `s != pressed` and `dcnt == DEBOUNCE_CYCLES-1`, the next edge toggles `pressed`, clears `dcnt`, and asserts the matching pulse for exactly that one cycle.
  - Any single sample with `s == pressed` restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` samples never propagate.
- State machine, encoded on `pressed` plus `longpress`:
  - IDLE (`pressed`=0) -> HELD on an accepted press.
  - HELD -> LONG when the hold counter `hcnt` reaches `LONG_CYCLES-1`.
  - HELD or LONG -> IDLE on an accepted release.
- Hold counter `hcnt`:
  - Cleared in IDLE.
  - Increments in HELD.
  - Saturates (stops counting) in LONG.
  - `longpress` is 1 only in LONG.
- `presspulse` and `releasepulse` are never high in the same cycle.
- Counters never wrap. `dcnt` cannot exceed `DEBOUNCE_CYCLES-1` because the toggle clears it.

## Timing
- Reset value of every output is 0. Reset clears the synchroniser, `dcnt`, `hcnt`, `rcnt` and the state, and forces IDLE.
- Reset asserted mid-press: every output drops to 0 immediately, with no `releasepulse`.
- Reset released with the button held: a press is accepted after the normal latency, with one `presspulse`.
- Press latency: if `switchin` falls before edge 0 and stays low, `s` is 1 from edge 2. `pressed` and `presspulse` are high after edge `DEBOUNCE_CYCLES+1`, a total of `DEBOUNCE_CYCLES+2` edges. Release latency is the same.
- `longpress` rises `LONG_CYCLES` edges after `pressed` rises. It falls on the same edge that `pressed` falls.
- Outputs are registered. There are no combinational paths from `switchin`.

## Configuration
- `BUTTON_AUTOREPEAT_EN` defined:
  - In LONG, the repeat counter `rcnt` counts from 0. Each time it reaches `REPEAT_CYCLES-1`, `repeatpulse` is high for one cycle and `rcnt` clears.
  - The first `repeatpulse` occurs `REPEAT_CYCLES` edges after `longpress` rises.
  - `rcnt` is cleared outside LONG.
- `BUTTON_AUTOREPEAT_EN` undefined:
  - `repeatpulse` is constant 0.
  - `rcnt` and `REPEAT_CYCLES` logic are not synthesised.
  - All other behaviour is identical.

## Test plan
Parameters for every scenario: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `REPEAT_CYCLES`=3, `CNT_WIDTH`=8.

- Reset: `reset_n`=0 with `switchin`=0, then release `reset_n` -> all outputs 0 during reset. `pressed`=1 with a single `presspulse` 6 edges after release.
- Clean press/release: `switchin` low for 20 cycles, then high -> `presspulse` once at edge 6, `pressed` high, `releasepulse` once 6 edges after `switchin` rises, and never both pulses in one cycle.
- Bounce rejection: `switchin` toggles low/high with runs of 1-3 cycles for 30 cycles, then stays high -> `pressed`, `presspulse` and `releasepulse` stay 0 throughout.
- Long press: hold low for 30 cycles -> `longpress` rises 10 edges after `pressed` and falls on the same edge as `pressed`.
- Auto-repeat:
  - With `BUTTON_AUTOREPEAT_EN`, hold for 30 cycles -> `repeatpulse` at 3, 6, 9… edges after `longpress` rises, ending at release.
  - Without the macro -> `repeatpulse` is always 0.
- Mid-hold reset: assert `reset_n`=0 while in LONG -> `pressed` and `longpress` go to 0 asynchronously with no `releasepulse`, and a press is re-accepted 6 edges after `reset_n` returns high.
